// File: rtl/mem_bus_pkg.sv
// Shared types for the cache-to-memory bus: fill FSM states,
// line geometry and big-endian word/byte helpers.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int LINE_WORDS = 4;
    localparam int WORD_BYTES = 4;

    // Element 0 is the lowest-addressed byte, which lands in bits 31:24.
    typedef logic [3:0][7:0] be_bytes_t;

    function automatic logic [31:0] be_pack(input be_bytes_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic be_bytes_t be_unpack(input logic [31:0] w);
        be_bytes_t b;
        b[0] = w[31:24];
        b[1] = w[23:16];
        b[2] = w[15:8];
        b[3] = w[7:0];
        return b;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with one synchronous big-endian word write
// port and one combinational big-endian word read port.
module mem_byte_array
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [7:0] mem [2**ADDR_W];

    be_bytes_t wb;
    be_bytes_t rb;

    assign wb = be_unpack(wdata);

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr]                 <= wb[0];
            mem[waddr + ADDR_W'(1)]    <= wb[1];
            mem[waddr + ADDR_W'(2)]    <= wb[2];
            mem[waddr + ADDR_W'(3)]    <= wb[3];
        end
    end

    always_comb begin
        rb    = '0;
        rb[0] = mem[raddr];
        rb[1] = mem[raddr + ADDR_W'(1)];
        rb[2] = mem[raddr + ADDR_W'(2)];
        rb[3] = mem[raddr + ADDR_W'(3)];
    end

    assign rdata = be_pack(rb);

endmodule

// File: rtl/main_mem_burst_responder.sv
// Main-memory model: streams a cache line on a falling MRd and
// absorbs write-through stores. Optional counters: MAIN_MEM_STATS_EN.
module main_mem_burst_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int BURST_LEN = LINE_WORDS,
    parameter int BEAT_W    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       AB,
    input  logic              MRd,
    input  logic              MWr,
    inout  wire logic [31:0]  MD,
    output logic              busy
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [15:0]       fill_cnt,
    output logic [15:0]       abort_cnt,
    output logic [15:0]       wr_cnt
`endif
);

    localparam int OFF_W = $clog2(WORD_BYTES * BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BURST_LEN - 1);

    state_t state_q;
    state_t state_d;

    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;
    logic [BEAT_W-1:0] beat_nx;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] ab_base;
    logic [ADDR_W-1:0] ab_word;
    logic [ADDR_W-1:0] rd_addr;

    logic [31:0] md_q;
    logic [31:0] rd_data;

    logic oe_q;
    logic oe_d;
    logic base_ld;
    logic wr_en;
    logic fill_done;
    logic abort;

    logic unused_ab;

    assign unused_ab = ^{AB[31:ADDR_W], AB[1:0]};

    assign ab_base = {AB[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign ab_word = {AB[ADDR_W-1:2], 2'b00};
    assign beat_nx = beat_q + BEAT_W'(1);

    mem_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (wr_en),
        .waddr (ab_word),
        .wdata (MD),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        oe_d      = 1'b0;
        base_ld   = 1'b0;
        wr_en     = 1'b0;
        fill_done = 1'b0;
        abort     = 1'b0;
        rd_addr   = ab_base;
        unique case (state_q)
            IDLE: begin
                if (!MRd) begin
                    state_d = BURST;
                    beat_d  = '0;
                    oe_d    = 1'b1;
                    base_ld = 1'b1;
                end else if (MWr) begin
                    wr_en = 1'b1;
                end
            end
            BURST: begin
                // A released request doubles as an idle edge for stores.
                if (MRd) begin
                    state_d = IDLE;
                    beat_d  = '0;
                    abort   = 1'b1;
                    wr_en   = MWr;
                end else if (beat_q == LAST) begin
                    state_d   = DRAIN;
                    beat_d    = '0;
                    fill_done = 1'b1;
                end else begin
                    beat_d  = beat_nx;
                    oe_d    = 1'b1;
                    rd_addr = base_q + (ADDR_W'(beat_nx) << 2);
                end
            end
            DRAIN: begin
                if (MRd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MD enable and data both come straight from flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            oe_q    <= 1'b0;
            md_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            oe_q    <= oe_d;
            if (base_ld) begin
                base_q <= ab_base;
            end
            if (oe_d) begin
                md_q <= rd_data;
            end
        end
    end

    assign MD   = oe_q ? md_q : 'z;
    assign busy = (state_q == BURST);

`ifdef MAIN_MEM_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fill_cnt  <= '0;
            abort_cnt <= '0;
            wr_cnt    <= '0;
        end else begin
            if (fill_done && fill_cnt != 16'hFFFF) begin
                fill_cnt <= fill_cnt + 16'd1;
            end
            if (abort && abort_cnt != 16'hFFFF) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
            if (wr_en && wr_cnt != 16'hFFFF) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_main_mem_burst_responder.sv
// Directed bench for main_mem_burst_responder: fills, stores,
// drain hold, abort, async reset and stores during a burst.
module tb_main_mem_burst_responder;

    logic        CLK;
    logic        RST;
    logic [31:0] AB;
    logic        MRd;
    logic        MWr;
    wire  [31:0] MD;
    logic        busy;
    logic [31:0] md_drv;
    logic        md_en;

`ifdef MAIN_MEM_STATS_EN
    logic [15:0] fill_cnt;
    logic [15:0] abort_cnt;
    logic [15:0] wr_cnt;
`endif

    int total;
    int bad;

    assign MD = md_en ? md_drv : 'z;

    main_mem_burst_responder dut (
        .CLK       (CLK),
        .RST       (RST),
        .AB        (AB),
        .MRd       (MRd),
        .MWr       (MWr),
        .MD        (MD),
        .busy      (busy)
`ifdef MAIN_MEM_STATS_EN
        ,
        .fill_cnt  (fill_cnt),
        .abort_cnt (abort_cnt),
        .wr_cnt    (wr_cnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Released bus: z in 4-state, undriven value in 2-state simulators.
    task automatic chk_z(input string tag);
        logic ok;
        ok = (MD === 32'hzzzz_zzzz) || (MD === 32'h0)
             || (MD === 32'hFFFF_FFFF);
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL %s observed=%h expected=released", tag, MD);
        end
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] d);
        AB     = addr;
        md_drv = d;
        md_en  = 1'b1;
        MWr    = 1'b1;
        clk1();
        MWr    = 1'b0;
        md_en  = 1'b0;
    endtask

    task automatic fill_chk(input string tag, input logic [31:0] addr,
                            input logic [3:0][31:0] exp);
        MRd = 1'b0;
        AB  = addr;
        clk1();
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_beat"}, MD, exp[k]);
            clk1();
        end
        chk_z({tag, "_end_z"});
        chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        MRd = 1'b1;
        clk1();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        RST    = 1'b1;
        MRd    = 1'b1;
        MWr    = 1'b0;
        AB     = '0;
        md_drv = '0;
        md_en  = 1'b0;

        #3;
        chk_z("rst_md_z");
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef MAIN_MEM_STATS_EN
        chk("rst_fill_cnt", {16'd0, fill_cnt}, 32'd0);
`endif
        #9 RST = 1'b0;
        clk1();

        wr_word(32'h20, 32'd9);
        wr_word(32'h24, 32'd10);
        wr_word(32'h28, 32'd11);
        wr_word(32'h2C, 32'd12);
        wr_word(32'h102, 32'hDEAD_BEEF);
        wr_word(32'h104, 32'h0000_0001);
        wr_word(32'h108, 32'h0000_0002);
        wr_word(32'h10C, 32'h0000_0003);
        wr_word(32'h40, 32'h1122_3344);
        wr_word(32'h44, 32'h5566_7788);
        wr_word(32'h48, 32'h99AA_BBCC);
        wr_word(32'h4C, 32'h0BAD_F00D);

        // Line 0x20 via an address inside the line.
        fill_chk("fill24", 32'h24, {32'd12, 32'd11, 32'd10, 32'd9});

        // AB[1:0] ignored on the store; aliased high AB bits ignored.
        fill_chk("fill100", 32'h0004_0100,
                 {32'd3, 32'd2, 32'd1, 32'hDEAD_BEEF});

        // Request held low past the burst stays in drain.
        MRd = 1'b0;
        AB  = 32'h20;
        for (int k = 0; k < 5; k++) clk1();
        for (int k = 0; k < 3; k++) begin
            chk("drain_busy", {31'd0, busy}, 32'd0);
            chk_z("drain_z");
            clk1();
        end
        MRd = 1'b1;
        clk1();
        MRd = 1'b0;
        clk1();
        chk("rearm_busy", {31'd0, busy}, 32'd1);
        chk("rearm_beat0", MD, 32'd9);
        clk1();
        chk("rearm_beat1", MD, 32'd10);
        clk1();
        chk("rearm_beat2", MD, 32'd11);
        clk1();
        chk("rearm_beat3", MD, 32'd12);
        clk1();
        MRd = 1'b1;
        clk1();

        // Async reset partway through beat 2.
        MRd = 1'b0;
        AB  = 32'h20;
        clk1();
        clk1();
        clk1();
        chk("rst_mid_beat2", MD, 32'd11);
        #2 RST = 1'b1;
        #1;
        chk_z("rst_mid_z");
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        #1;
        RST = 1'b0;
        MRd = 1'b1;
        clk1();

        // Abort after beat 1.
        MRd = 1'b0;
        AB  = 32'h20;
        clk1();
        chk("abort_beat0", MD, 32'd9);
        clk1();
        chk("abort_beat1", MD, 32'd10);
        MRd = 1'b1;
        clk1();
        chk_z("abort_z");
        chk("abort_busy", {31'd0, busy}, 32'd0);
`ifdef MAIN_MEM_STATS_EN
        chk("abort_cnt", {16'd0, abort_cnt}, 32'd1);
        chk("abort_fill_cnt", {16'd0, fill_cnt}, 32'd0);
        chk("abort_wr_cnt", {16'd0, wr_cnt}, 32'd0);
`endif

        // Memory survived the reset.
        fill_chk("post_rst", 32'h28, {32'd12, 32'd11, 32'd10, 32'd9});

        // Stores during a burst are dropped; AB moves are ignored.
        MRd = 1'b0;
        AB  = 32'h40;
        clk1();
        chk("bw_beat0", MD, 32'h1122_3344);
        MWr = 1'b1;
        AB  = 32'h40;
        clk1();
        chk("bw_beat1", MD, 32'h5566_7788);
        AB  = 32'h200;
        clk1();
        chk("bw_beat2", MD, 32'h99AA_BBCC);
        clk1();
        chk("bw_beat3", MD, 32'h0BAD_F00D);
        clk1();
        chk_z("bw_end_z");
        MWr = 1'b0;
        MRd = 1'b1;
        clk1();
        fill_chk("bw_recheck", 32'h40,
                 {32'h0BAD_F00D, 32'h99AA_BBCC,
                  32'h5566_7788, 32'h1122_3344});
`ifdef MAIN_MEM_STATS_EN
        chk("end_fill_cnt", {16'd0, fill_cnt}, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_mem_burst_responder.md
Name: main_mem_burst_responder

Overview:
- Main-memory model that answers the cache's line-fill read protocol and absorbs write-through stores.
- Sits on the cache-to-memory side: shared `AB` address bus, bidirectional `MD` data bus, active-low `MRd` read request from the cache, active-high `MWr` write strobe.
- On a falling `MRd` it streams one cache line, `BURST_LEN` 32-bit big-endian words, one word per clock, then releases `MD`.

Parameters:
- `ADDR_W`, 18: byte-address bits decoded; memory holds 2^`ADDR_W` bytes; `AB` bits above are ignored (aliasing).
- `BURST_LEN`, 4: words per line fill; power of two, 2..16; line size = 4*`BURST_LEN` bytes.
- `BEAT_W`, 4: beat-counter width; must satisfy 2^`BEAT_W` >= `BURST_LEN`.

Ports:
- `CLK`, in, 1: clock; all state changes on the rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `AB`, in, 32: byte address from the cache.
- `MRd`, in, 1: active-low line-fill request, held low by the cache for the whole burst.
- `MWr`, in, 1: active-high write-through strobe, one word per asserted edge.
- `MD`, inout, 32: memory data bus; driven only while beats are presented, high-Z otherwise.
- `busy`, out, 1: high while a burst is in progress (`BURST` state).

Behaviour:
- Storage is a byte array, big-endian: word byte 0 maps to `MD[31:24]`.
- Line base = {`AB[ADDR_W-1:log2(4*BURST_LEN)]`, zeros}.
- Beat k is read from line base + 4k.
- States are `IDLE`, `BURST`, `DRAIN`.
- Reset (async, any state): state = `IDLE`, beat = 0, `MD` = high-Z, `busy` = 0, line-base register = 0. Memory contents are not cleared. If `RST` is asserted mid-burst, `MD` is released immediately (async).
- `IDLE`:
  - Edge with `MRd`=0: latch line base, beat = 0, drive word 0 on `MD` after this edge (1-cycle latency), `busy` = 1, go to `BURST`.
  - Else, edge with `MWr`=1: write `MD` to word address {`AB[ADDR_W-1:2]`, 2'b00}. `AB[1:0]` is ignored.
- `BURST`, at each edge:
  - If `MRd`=1 (abort): release `MD`, `busy` = 0, go to `IDLE`; the aborting edge is also treated as `IDLE` (an `MWr` on it is honoured).
  - Else if beat = `BURST_LEN`-1: release `MD`, `busy` = 0, go to `DRAIN`.
  - Else: beat+1, drive the next word.
- Timing contract with the cache: the cache samples word k at edge k+1 after the request edge E0. The last word is sampled at E`BURST_LEN`, the same edge at which the responder leaves `BURST`.
- `DRAIN`: `MD` high-Z; stay while `MRd`=0; go to `IDLE` on an edge with `MRd`=1. A request held low never re-triggers; rearming needs at least one high sample.
- `MWr` while in `BURST` or `DRAIN` is ignored: the bus is owned by the fill. `MWr` and `MRd`=0 on the same `IDLE` edge: the read wins and the write is dropped.
- The latched line base is used for the whole burst; `AB` changes mid-burst are ignored.
- No combinational path from inputs to `MD` data; `MD` enable and data come from registers only.

Optional Feature:
- Macro: `MAIN_MEM_STATS_EN`.
- Defined: adds outputs `fill_cnt` (16 bits), `abort_cnt` (16 bits) and `wr_cnt` (16 bits).
  - `fill_cnt` increments on each completed burst.
  - `abort_cnt` increments on each `MRd`-high exit from `BURST`.
  - `wr_cnt` increments on each accepted write.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `mem_bus_pkg` holds:
  - state encoding: `IDLE`=2'd0, `BURST`=2'd1, `DRAIN`=2'd2;
  - `LINE_WORDS`=4 and `WORD_BYTES`=4;
  - a big-endian pack/unpack function pair (4 bytes <-> 32-bit word).
- One sub-module, `mem_byte_array`: byte storage with a synchronous 32-bit big-endian write port and a combinational 32-bit read port. The FSM, beat counter and tri-state control stay in the top module.

Test Plan:
- Preload bytes 0x20..0x2F with words 9,10,11,12; `MRd` low at E0 with `AB`=0x0000_0024 -> `MD` = 9,10,11,12 after E0..E3; `MD` high-Z after E4; `busy` high exactly for those 4 cycles.
- `IDLE`, `MWr`=1, `AB`=0x0000_0102, `MD`=0xDEADBEEF -> bytes 0x100..0x103 = DE AD BE EF; a following fill of line 0x100 returns 0xDEADBEEF as beat 0.
- `MRd` held low 3 cycles past burst end -> state stays `DRAIN`, no second burst. `MRd` high 1 cycle then low -> new burst starts.
- `MRd` rises after beat 1 -> `MD` high-Z after that edge, state `IDLE`; with `MAIN_MEM_STATS_EN`: `abort_cnt`=1, `fill_cnt`=0.
- `RST` pulsed asynchronously mid-beat 2 -> `MD` high-Z and `busy`=0 before the next edge; memory contents unchanged.
- `MWr`=1 during `BURST` with `AB`=0x40 -> bytes 0x40..0x43 unchanged; burst data unaffected.
